// File: rtl/serial_sched_pkg.sv
// serial_sched_pkg: shared types and helpers for the serial frame scheduler.
//   sched_state_t : top-level frame sequencing states
//   rr_pick()     : round-robin pick of the first set bit at or above a pointer
//   MIN_CLK_DIV   : smallest legal sclk half-period in system clocks
package serial_sched_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, GAP} sched_state_t;

  localparam int unsigned MIN_CLK_DIV = 2;
  localparam int unsigned MAX_CLIENTS = 8;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of v scanning upward from ptr, modulo n (n <= MAX_CLIENTS,
  // ptr < n). Since ptr + i < 2n, a single conditional subtract wraps it.
  function automatic rr_pick_t rr_pick(input logic [MAX_CLIENTS-1:0] v,
                                       input logic [2:0] ptr,
                                       input int unsigned n);
    rr_pick_t   r;
    logic [3:0] s;
    r = '0;
    for (int unsigned i = 0; i < MAX_CLIENTS; i++) begin
      s = {1'b0, ptr} + 4'(i);
      if (s >= 4'(n)) s = s - 4'(n);
      if (!r.valid && (i < n) && v[s[2:0]]) begin
        r.valid = 1'b1;
        r.idx   = s[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_shift_engine.sv
// serial_shift_engine: sclk divider, bit counter and shift/sample registers.
//   clk, aclr_n, sclr : clock, async active-low reset, sync clear (abort)
//   start, load_data  : begin a frame with load_data, MSB first
//   sdi_sel           : readback bit of the served client
//   sclk, sdo         : serial clock (idle low) and current MSB
//   bit_done          : strobe on the cycle whose edge drops sclk
//   frame_done        : level, the bit in flight is the last of the frame
//   rx_data           : readback word assembled MSB first
module serial_shift_engine
  import serial_sched_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned CLK_DIV = 18
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             sclr,
  input  logic             start,
  input  logic [WIDTH-1:0] load_data,
  input  logic             sdi_sel,
  output logic             sclk,
  output logic             sdo,
  output logic             bit_done,
  output logic             frame_done,
  output logic [WIDTH-1:0] rx_data
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BW = $clog2(WIDTH + 1);

  logic             active;
  logic [DW-1:0]    div;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] sr;
  logic             div_last;

  assign div_last   = active && (div == DW'(CLK_DIV - 1));
  assign bit_done   = div_last && sclk;
  assign frame_done = (bit_cnt == BW'(WIDTH - 1));
  assign sdo        = sr[WIDTH-1];

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      active  <= 1'b0;
      div     <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      sr      <= '0;
      rx_data <= '0;
    end else if (sclr) begin
      active  <= 1'b0;
      div     <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      sr      <= '0;
      rx_data <= '0;
    end else if (start) begin
      active  <= 1'b1;
      div     <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      sr      <= load_data;
    end else if (active) begin
      if (div_last) begin
        div  <= '0;
        sclk <= ~sclk;
        if (!sclk) begin
          rx_data <= (rx_data << 1) | WIDTH'(sdi_sel);
        end else if (frame_done) begin
          // Last bit is not shifted out so sdo keeps it through LATCH.
          active <= 1'b0;
        end else begin
          sr      <= sr << 1;
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_sched.sv
// serial_sched: round-robin sharing of one serial shift engine between
// N_CLIENTS register-image clients (IDLE -> SHIFT -> LATCH -> GAP).
//   clk, aclr_n, sclr : clock, async active-low reset, sync clear
//   req, data         : per-client level request and frame word
//   ack, done         : per-client capture / frame-complete pulses
//   rdata             : readback of the last completed frame
//   busy, grant       : engine active, client being served
//   sclk, sdo, sdi    : shared serial clock/data, per-client readback
//   lock              : per-client latch strobe
// Optional: `define SERIAL_SCHED_REFRESH_EN keeps per-client shadows of the
// last acked word and refreshes served clients whenever no req is pending.
module serial_sched
  import serial_sched_pkg::*;
#(
  parameter  int unsigned N_CLIENTS = 2,
  parameter  int unsigned WIDTH     = 16,
  parameter  int unsigned CLK_DIV   = 18,
  localparam int unsigned GW        = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1
) (
  input  logic                       clk,
  input  logic                       aclr_n,
  input  logic                       sclr,
  input  logic [N_CLIENTS-1:0]       req,
  input  logic [N_CLIENTS*WIDTH-1:0] data,
  output logic [N_CLIENTS-1:0]       ack,
  output logic [N_CLIENTS-1:0]       done,
  output logic [WIDTH-1:0]           rdata,
  output logic                       busy,
  output logic [GW-1:0]              grant,
  output logic                       sclk,
  output logic                       sdo,
  output logic [N_CLIENTS-1:0]       lock,
  input  logic [N_CLIENTS-1:0]       sdi
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (CLK_DIV < MIN_CLK_DIV) begin : g_bad_clk_div
    $error("serial_sched: CLK_DIV must be >= %0d", MIN_CLK_DIV);
  end
  if (N_CLIENTS < 1 || N_CLIENTS > MAX_CLIENTS) begin : g_bad_clients
    $error("serial_sched: N_CLIENTS must be 1..%0d", MAX_CLIENTS);
  end
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("serial_sched: WIDTH must be 1..32");
  end

  function automatic logic [N_CLIENTS-1:0] onehot(input logic [GW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  sched_state_t     state;
  logic [DW-1:0]    cnt;
  logic [GW-1:0]    ptr;
  logic             cnt_last, arb_pt;
  rr_pick_t         req_pick, ref_pick;
  logic             start_req, start_ref, start;
  logic [GW-1:0]    win, win_next;
  logic [WIDTH-1:0] win_data;
  logic             eng_sdo, eng_bit_done, eng_last;
  logic [WIDTH-1:0] eng_rx;

  assign cnt_last = (cnt == DW'(CLK_DIV - 1));
  // Arbitration also happens on the edge that leaves GAP, so a pending
  // request starts in what would be the first IDLE cycle with no dead time.
  assign arb_pt   = (state == IDLE) || ((state == GAP) && cnt_last);
  assign busy     = (state != IDLE);
  assign sdo      = ((state == SHIFT) || (state == LATCH)) && eng_sdo;

  always_comb req_pick = rr_pick(MAX_CLIENTS'(req), 3'(ptr), N_CLIENTS);

`ifdef SERIAL_SCHED_REFRESH_EN
  logic [WIDTH-1:0]     shadow [N_CLIENTS];
  logic [N_CLIENTS-1:0] shadow_vld;

  always_comb ref_pick = rr_pick(MAX_CLIENTS'(shadow_vld), 3'(ptr), N_CLIENTS);

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n)        shadow_vld      <= '0;
    else if (sclr)      shadow_vld      <= '0;
    else if (start_req) shadow_vld[win] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (start_req) shadow[win] <= data[win*WIDTH +: WIDTH];
  end
`else
  always_comb ref_pick = '0;
`endif

  always_comb begin
    start_req = arb_pt && req_pick.valid;
    start_ref = arb_pt && !req_pick.valid && ref_pick.valid;
    win       = start_req ? GW'(req_pick.idx) : GW'(ref_pick.idx);
    win_next  = (win == GW'(N_CLIENTS - 1)) ? '0 : win + 1'b1;
    win_data  = data[win*WIDTH +: WIDTH];
`ifdef SERIAL_SCHED_REFRESH_EN
    if (start_ref) win_data = shadow[win];
`endif
  end

  assign start = start_req || start_ref;

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= '0;
      grant <= '0;
      ack   <= '0;
      done  <= '0;
      lock  <= '0;
      rdata <= '0;
    end else if (sclr) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= '0;
      grant <= '0;
      ack   <= '0;
      done  <= '0;
      lock  <= '0;
      rdata <= '0;
    end else begin
      ack  <= '0;
      done <= '0;
      case (state)
        IDLE: ;
        SHIFT: begin
          if (eng_bit_done && eng_last) begin
            state <= LATCH;
            cnt   <= '0;
            lock  <= onehot(grant);
          end
        end
        LATCH: begin
          if (cnt_last) begin
            state <= GAP;
            cnt   <= '0;
            lock  <= '0;
            done  <= onehot(grant);
            rdata <= eng_rx;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          cnt <= cnt_last ? '0 : cnt + 1'b1;
          if (cnt_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (start) begin
        state <= SHIFT;
        grant <= win;
        ptr   <= win_next;
        if (start_req) ack <= onehot(win);
      end
    end
  end

  serial_shift_engine #(
    .WIDTH   (WIDTH),
    .CLK_DIV (CLK_DIV)
  ) u_engine (
    .clk        (clk),
    .aclr_n     (aclr_n),
    .sclr       (sclr),
    .start      (start),
    .load_data  (win_data),
    .sdi_sel    (sdi[grant]),
    .sclk       (sclk),
    .sdo        (eng_sdo),
    .bit_done   (eng_bit_done),
    .frame_done (eng_last),
    .rx_data    (eng_rx)
  );

endmodule

// File: tb/tb_serial_sched.sv
// tb_serial_sched: randomized and directed stimulus for serial_sched, checked
// every cycle against a frame-timeline reference model (N=2, W=16, D=4).
module tb_serial_sched;

  localparam int unsigned N      = 2;
  localparam int unsigned W      = 16;
  localparam int unsigned D      = 4;
  localparam int unsigned BITC   = 2 * D;
  localparam int unsigned T_LOCK = W * BITC;
  localparam int unsigned T_DONE = T_LOCK + D;
  localparam int unsigned T_END  = T_DONE + D;

  logic           clk = 1'b0, aclr_n = 1'b0, sclr = 1'b0;
  logic [N-1:0]   req = '0, sdi = '0;
  logic [N*W-1:0] data = '0;
  logic [N-1:0]   ack, done, lock;
  logic [W-1:0]   rdata;
  logic           busy, sclk, sdo;
  logic [0:0]     grant;

  serial_sched #(.N_CLIENTS(N), .WIDTH(W), .CLK_DIV(D)) dut (
    .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .req(req), .data(data),
    .ack(ack), .done(done), .rdata(rdata), .busy(busy), .grant(grant),
    .sclk(sclk), .sdo(sdo), .lock(lock), .sdi(sdi)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  string        phase = "reset";
  int unsigned  cyc = 0, m_start = 0, m_cli = 0, m_grant = 0, m_ptr = 0;
  logic         m_busy = 1'b0, m_acked = 1'b0;
  logic [W-1:0] m_word = '0, m_rdw = '0, m_rdata = '0;
  logic [W-1:0] m_shadow [N];
  logic [N-1:0] m_shv = '0;
  logic [W-1:0] sdi_word [N];

  function automatic int first_from(input logic [N-1:0] v, input int unsigned p);
    for (int unsigned i = 0; i < N; i++)
      if (v[(p + i) % N]) return int'((p + i) % N);
    return -1;
  endfunction

  task automatic m_reset();
    m_busy = 1'b0; m_ptr = 0; m_grant = 0; m_rdata = '0; m_shv = '0;
  endtask

  task automatic m_decide();
    int w;
    w = first_from(req, m_ptr);
    if (w >= 0) begin
      m_acked = 1'b1;
      m_word  = data[w*W +: W];
      m_shadow[w] = m_word;
      m_shv[w]    = 1'b1;
    end
`ifdef SERIAL_SCHED_REFRESH_EN
    else begin
      w = first_from(m_shv, m_ptr);
      if (w >= 0) begin
        m_acked = 1'b0;
        m_word  = m_shadow[w];
      end
    end
`endif
    if (w >= 0) begin
      m_busy  = 1'b1;
      m_start = cyc + 1;
      m_cli   = w;
      m_grant = w;
      m_ptr   = (w + 1) % N;
      m_rdw   = sdi_word[w];
    end
  endtask

  initial forever begin
    int unsigned off;
    logic [N-1:0] e_ack, e_done, e_lock;
    logic e_sclk, e_sdo;
    @(negedge clk);
    cyc++;
    if (!aclr_n) begin
      chk({phase, "/areset"}, {ack, done, lock, busy, sclk, sdo, grant, rdata}, '0);
      m_reset();
    end else begin
      off    = cyc - m_start;
      e_ack  = '0; e_done = '0; e_lock = '0; e_sclk = 1'b0; e_sdo = 1'b0;
      if (m_busy) begin
        if (off == 0 && m_acked) e_ack[m_cli] = 1'b1;
        e_sclk = (off < T_LOCK) && ((off % BITC) >= D);
        if (off < T_DONE) e_sdo = m_word[W - 1 - ((off / BITC < W) ? off / BITC : W - 1)];
        if (off >= T_LOCK && off < T_DONE) e_lock[m_cli] = 1'b1;
        if (off == T_DONE) begin
          e_done[m_cli] = 1'b1;
          m_rdata = m_rdw;
        end
      end
      chk(phase, {ack, done, lock, busy, sclk, sdo, grant, rdata},
          {e_ack, e_done, e_lock, m_busy, e_sclk, e_sdo, 1'(m_grant), m_rdata});
      // Readback slave: presents the frame's readback bit for this bit slot.
      sdi = N'($urandom);
      if (m_busy && off < T_LOCK) sdi[m_cli] = m_rdw[W - 1 - off / BITC];
      if (m_busy && off == T_END - 1) m_busy = 1'b0;
      if (sclr) m_reset();
      else if (!m_busy) m_decide();
    end
  end

  // ---------------- stimulus ----------------
  logic auto_drop = 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_drop) req = req & ~ack;
  endtask

  task automatic run(input int unsigned n);
    repeat (n) tick();
  endtask

  task automatic do_sclr();
    sclr = 1'b1; tick(); sclr = 1'b0;
  endtask

  task automatic wait_ack(input int unsigned k, input int unsigned budget);
    int unsigned n = 0;
    do begin tick(); n++; end while (!ack[k] && n < budget);
    chk({phase, "/ack_wait"}, 64'(ack[k]), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < N; k++) sdi_word[k] = '0;
    run(3);
    aclr_n = 1'b1;
    run(2);

    phase = "single";
    sdi_word[0] = 16'h1234; sdi_word[1] = 16'hFFFF;
    data[0 +: W] = 16'hA5C3; data[W +: W] = 16'h5555;
    req[0] = 1'b1;
    wait_ack(0, 5);
    run(T_END + 10);
    chk("single_rdata", 64'(rdata), 64'h1234);
    do_sclr();

    phase = "alternate";
    auto_drop = 1'b0;
    sdi_word[0] = 16'hBEEF; sdi_word[1] = 16'h0F0F;
    req = '1;
    run(5 * T_END);
    req = '0;
    auto_drop = 1'b1;
    do_sclr();

    phase = "late_req";
    data = {16'h3C3C, 16'h8001};
    sdi_word[0] = 16'hC001; sdi_word[1] = 16'h7E57;
    req[0] = 1'b1;
    wait_ack(0, 5);
    run(60);
    req[1] = 1'b1;
    wait_ack(1, T_END + 5);
    run(T_END + 10);
    chk("late_req_rdata", 64'(rdata), 64'h7E57);
    do_sclr();

    phase = "sclr_abort";
    req[0] = 1'b1;
    wait_ack(0, 5);
    run(10);
    req[1] = 1'b1;
    run(39);
    do_sclr();
    chk("sclr_busy", 64'(busy), 64'd0);
    wait_ack(1, 5);
    run(T_END + 10);
    do_sclr();

    phase = "async_reset";
    req[0] = 1'b1;
    wait_ack(0, 5);
    run(30);
    aclr_n = 1'b0;
    run(2);
    aclr_n = 1'b1;
    req[0] = 1'b1;
    wait_ack(0, 5);
    run(T_END + 10);
    do_sclr();

    phase = "refresh";
    data[0 +: W] = 16'h00FF;
    sdi_word[0] = 16'hA0A0;
    req[0] = 1'b1;
    wait_ack(0, 5);
    run(3 * T_END);
    req[1] = 1'b1;
    wait_ack(1, 2 * T_END);
    run(T_END + 10);
    do_sclr();

    phase = "random";
    for (int unsigned c = 0; c < 4000; c++) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (!req[k] && $urandom_range(0, 99) < 3) begin
          req[k] = 1'b1;
          data[k*W +: W] = W'($urandom);
        end else if (req[k] && $urandom_range(0, 999) < 2) begin
          req[k] = 1'b0;
        end
        if ($urandom_range(0, 299) == 0) sdi_word[k] = W'($urandom);
      end
      sclr = ($urandom_range(0, 1499) == 0);
      tick();
    end
    sclr = 1'b0;
    run(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_sched.md
Name: serial_sched

Overview:
- Shares one serial shift engine (sclk/sdo/sdi) between N_CLIENTS register-image clients, e.g. generator settings and pult indicator word.
- Each client has its own latch strobe (lock) and its own readback input (sdi).
- Round-robin arbitration on a req/ack handshake; one frame per grant; per-client done pulse carries the shifted-in readback word.
- Sits between the control-bus register file and the external serial daisy chains.

Parameters:
N_CLIENTS, 2, number of requesters (1..8)
WIDTH, 16, frame length in bits, same for all clients (1..32)
CLK_DIV, 18, system clocks per sclk half-period (>=2; elaboration error otherwise)

Ports:
clk  in  1  system clock
aclr_n  in  1  asynchronous reset, active low
sclr  in  1  synchronous clear, active high
req  in  N_CLIENTS  per-client request, level, held until ack
data  in  N_CLIENTS*WIDTH  frame words, client k at [k*WIDTH +: WIDTH]
ack  out  N_CLIENTS  one-cycle pulse: data of that client captured
done  out  N_CLIENTS  one-cycle pulse: frame latched, rdata valid
rdata  out  WIDTH  readback word of the last completed frame
busy  out  1  engine not IDLE
grant  out  $clog2(N_CLIENTS) (min 1)  index of client being served
sclk  out  1  shared serial clock, idle low
sdo  out  1  shared serial data, MSB first
lock  out  N_CLIENTS  per-client latch strobe, active high
sdi  in  N_CLIENTS  per-client readback data

Behaviour:
- Reset (aclr_n low, async) and sclr (sync): all outputs 0; state IDLE; rr pointer 0, so client 0 has top priority; divider and bit counter 0.
- States: IDLE -> SHIFT -> LATCH -> GAP -> IDLE.
- IDLE:
  - If any req is set, the winner is the first set req scanning from the rr pointer upward, modulo N_CLIENTS.
  - On the next edge: ack[winner]=1 for exactly one cycle; shift register <= data[winner]; grant <= winner; rr pointer <= winner+1 mod N; busy <= 1; state -> SHIFT.
  - A client must not rely on a second ack within the same frame. req still high after ack queues the next frame.
- SHIFT:
  - sdo presents the current MSB throughout the bit; sclk is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - sdi[grant] is sampled on the clk edge that raises sclk; the shift occurs on the falling sclk edge.
  - After WIDTH bits, with sclk back low: state -> LATCH.
- LATCH: lock[grant]=1 for CLK_DIV cycles; sclk low; sdo holds last bit.
- GAP (lock falling edge):
  - done[grant] pulses for 1 cycle; rdata <= assembled readback word, MSB first, held until the next done.
  - Stay CLK_DIV cycles with all lines low, then -> IDLE; busy drops on entering IDLE.
- Frame length from ack to IDLE: WIDTH*2*CLK_DIV + 2*CLK_DIV cycles.
- Next grant may be issued in the first IDLE cycle (no extra dead time).
- Req of a non-granted client arriving mid-frame waits; no loss, no preemption.
- req deasserted before ack: request withdrawn, no frame.
- sclr or reset mid-frame:
  - Abort immediately; lock never pulses for a partial frame; no done.
  - The acked frame is lost; the client re-requests.
- Divider and bit counter widths: $clog2(CLK_DIV) and $clog2(WIDTH+1); no wrap hazard at maximum parameter values.

Optional Feature:
- Macro SERIAL_SCHED_REFRESH_EN.
- Defined:
  - The block keeps a per-client shadow of the last acked data.
  - Once a client has been served at least once, an IDLE cycle with no req starts a refresh frame for the next client in rr order whose shadow is valid. No ack is issued; done and rdata behave as for a normal frame.
  - Explicit req always wins over refresh at the arbitration point. This keeps external latches continuously rewritten against noise.
- Not defined: no shadows; the engine idles when no req is set.

Decomposition:
- Package serial_sched_pkg:
  - state enum sched_state_t {IDLE, SHIFT, LATCH, GAP};
  - function rr_pick(req, ptr) returning winner index and valid;
  - localparam for the minimum CLK_DIV.
- Sub-module serial_shift_engine: divider, bit counter, shift/sample register, sclk/sdo generation.
  - Interface: start, load data, sdi_sel, bit_done, frame_done.
  - The top holds the arbiter, FSM states LATCH/GAP, lock/done decode and the refresh shadows.

Test Plan (N_CLIENTS=2, WIDTH=16, CLK_DIV=4):
- Single req[0], data0=16'hA5C3, sdi[0] driven with 16'h1234 -> ack[0] one cycle later; sdo bits A5C3 MSB first, 8 clk per bit; lock[0] high 4 cycles; done[0] at cycle 132 after ack; rdata=16'h1234; lock[1] never rises.
- req[0] and req[1] both high continuously from reset -> grants alternate 0,1,0,1; successive acks exactly 136 cycles apart.
- req[1] raised mid-frame of client 0 -> served at the first IDLE cycle after frame 0; rdata of frame 0 unchanged until done[1].
- sclr asserted 50 cycles into a frame -> next cycle all outputs 0, busy 0, no lock and no done pulse; pending req[1] granted first because the rr pointer was reset to 0 and req[0] is low.
- aclr_n pulsed low mid-SHIFT -> immediate (async) zero outputs; after release a new req gives a clean full frame.
- With SERIAL_SCHED_REFRESH_EN: after one req[0] frame of 16'h00FF and no further reqs -> back-to-back refresh frames of 16'h00FF on client 0 only, no ack, one done[0] per frame; a new req[1] is served next.
